stream_width_down: RTL and testbench

Valid/ready stream width down-converter that sits on the read side of `sync_fifo`. It accepts one wide word per handshake from the FIFO output (`valid_o`/`ready_o`/`rd_data_o`) and emits it as `RATIO` narrow beats on a downstream valid/ready stream, flagging the final beat of each word. A holding register lets the next wide word load in the same cycle the last narrow beat is accepted, so sustained throughput is one narrow beat per clock.

---
 rtl/stream_width_down.sv | 157 +++++++++++++++
 tb/tb_stream_width_down.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_width_down.sv
// stream_width_down
// Valid/ready width down-converter. One wide word is taken per upstream
// handshake and replayed as RATIO narrow beats downstream, with last_o
// marking the final beat of each word. When the last beat of a word is
// accepted, the next wide word can be loaded into the holding register in
// the same cycle. This gives one narrow beat per clock with no gap between
// words.
//
// Only ready_o reaches ready_i combinationally. data_o, valid_o and last_o
// are decoded purely from registers.

module stream_width_down #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    // upstream (wide) side, normally the read port of a FIFO
    input  logic                 valid_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    output logic                 ready_i,
    // downstream (narrow) side
    input  logic                 ready_o,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [BEAT_W-1:0] FIRST_BEAT = BEAT_W'(0);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(RATIO - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);

    // FSM encoding: the state is carried by full_q itself
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0]  hold_q;   // word currently being serialised
    logic                 full_q;   // hold_q carries unsent beats
    logic [BEAT_W-1:0]    beat_q;   // index of the beat presented now

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                 is_last;
    logic                 up_fire;
    logic                 dn_fire;
    logic [BEAT_W-1:0]    slice_sel;
    logic [OUT_WIDTH-1:0] slice_mux;

    // Final-beat flag, only meaningful while a word is held
    always_comb begin
        is_last = 1'b0;
        if (full_q == ST_BUSY) begin
            is_last = (beat_q == LAST_BEAT);
        end else begin
            is_last = 1'b0;
        end
    end

    // Downstream handshake. The upstream side may load when the holder is
    // empty, or when the last beat is leaving in this same cycle.
    always_comb begin
        dn_fire = full_q && ready_o;
        ready_i = (full_q == ST_EMPTY) || (dn_fire && is_last);
        up_fire = valid_i && ready_i;
    end

    // Map the beat counter to a slice index according to beat order
    always_comb begin
        slice_sel = FIRST_BEAT;
        if (LSB_FIRST != 0) begin
            slice_sel = beat_q;
        end else begin
            slice_sel = LAST_BEAT - beat_q;
        end
    end

    // Slice multiplexer over the holding register
    always_comb begin
        slice_mux = {OUT_WIDTH{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            if (slice_sel == BEAT_W'(i)) begin
                slice_mux = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
            end else begin
                slice_mux = slice_mux;
            end
        end
    end

    // Downstream outputs. These depend on registers only.
    always_comb begin
        valid_o = full_q;
        last_o  = is_last;
        if (full_q == ST_BUSY) begin
            data_o = slice_mux;
        end else begin
            data_o = {OUT_WIDTH{1'b0}};
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Load, advance and drain the holding register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hold_q <= {IN_WIDTH{1'b0}};
            full_q <= ST_EMPTY;
            beat_q <= FIRST_BEAT;
        end else begin
            case (full_q)
                ST_EMPTY: begin
                    if (up_fire) begin
                        hold_q <= data_i;
                        beat_q <= FIRST_BEAT;
                        full_q <= ST_BUSY;
                    end else begin
                        beat_q <= FIRST_BEAT;
                    end
                end
                ST_BUSY: begin
                    if (dn_fire && is_last) begin
                        beat_q <= FIRST_BEAT;
                        if (up_fire) begin
                            // the next word follows with no bubble
                            hold_q <= data_i;
                            full_q <= ST_BUSY;
                        end else begin
                            full_q <= ST_EMPTY;
                        end
                    end else if (dn_fire) begin
                        beat_q <= beat_q + BEAT_ONE;
                    end else begin
                        // stalled downstream: hold everything
                        beat_q <= beat_q;
                    end
                end
                default: begin
                    full_q <= ST_EMPTY;
                    beat_q <= FIRST_BEAT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_width_down.sv
// Directed bench for stream_width_down: a per-cycle vector table on the
// default 32->8 LSB-first instance, plus hand sequences for MSB-first
// 16->4 ordering, reset mid-word and a FIFO-fed random back-pressure run.

module tb_stream_width_down;

    logic        clk;
    logic        rstn_i;

    // default instance (32 -> 8, LSB first)
    logic        valid_i;
    logic [31:0] data_i;
    logic        ready_i;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        last_o;

    // MSB-first instance (16 -> 4)
    logic        m_valid_i;
    logic [15:0] m_data_i;
    logic        m_ready_i;
    logic        m_ready_o;
    logic [3:0]  m_data_o;
    logic        m_valid_o;
    logic        m_last_o;

    int checks_total;
    int checks_passed;

    stream_width_down dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_i (ready_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o)
    );

    stream_width_down #(
        .IN_WIDTH  (16),
        .OUT_WIDTH (4),
        .LSB_FIRST (0)
    ) dut_msb (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .valid_i (m_valid_i),
        .data_i  (m_data_i),
        .ready_i (m_ready_i),
        .ready_o (m_ready_o),
        .data_o  (m_data_o),
        .valid_o (m_valid_o),
        .last_o  (m_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vi;
        logic [31:0] di;
        logic        ro;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_last;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vi, input logic [31:0] di, input logic ro,
                       input logic ev, input logic [7:0] ed, input logic el,
                       input logic er);
        vec_t v;
        v.vi = vi; v.di = di; v.ro = ro;
        v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_ready = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] fifo_q[$];
        int got;
        int step_name;

        checks_total  = 0;
        checks_passed = 0;
        rstn_i    = 1'b0;
        valid_i   = 1'b1;
        data_i    = 32'hCAFE_F00D;
        ready_o   = 1'b1;
        m_valid_i = 1'b0;
        m_data_i  = 16'h0000;
        m_ready_o = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_last",  {31'b0, last_o},  32'd0);
        check("rst_data",  {24'b0, data_o},  32'd0);
        check("rst_ready", {31'b0, ready_i}, 32'd1);
        @(negedge clk);
        rstn_i  = 1'b1;
        valid_i = 1'b0;

        // ---------------- vector table ----------------
        //   vi    di            ro    ev    ed     el    er
        // single word
        add(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
        // back-to-back
        add(1'b1, 32'h03020100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        add(1'b1, 32'h07060504, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
        // stall on beat 1 for 3 cycles, with upstream noise while ready_i=0
        add(1'b1, 32'h44332211, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b1, 32'h12121212, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
        add(1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // stall on the last beat with upstream waiting, then reload
        add(1'b1, 32'h55667788, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b1, 32'h99999999, 1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
        add(1'b1, 32'h99999999, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        add(1'b1, 32'h99999999, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
        add(1'b1, 32'h0A0B0C0D, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        add(1'b1, 32'h0A0B0C0D, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0B, 1'b0, 1'b0);
        add(1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b1);
        add(1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid_i = vecs[i].vi;
            data_i  = vecs[i].di;
            ready_o = vecs[i].ro;
            #1;
            step_name = i;
            check($sformatf("vec%0d_valid", step_name), {31'b0, valid_o}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_data", step_name),  {24'b0, data_o},  {24'b0, vecs[i].e_data});
            check($sformatf("vec%0d_last", step_name),  {31'b0, last_o},  {31'b0, vecs[i].e_last});
            check($sformatf("vec%0d_ready", step_name), {31'b0, ready_i}, {31'b0, vecs[i].e_ready});
        end

        // ---------------- MSB first, 16 -> 4 ----------------
        @(negedge clk);
        m_valid_i = 1'b1;
        m_data_i  = 16'hABCD;
        m_ready_o = 1'b1;
        #1;
        check("msb_idle_valid", {31'b0, m_valid_o}, 32'd0);
        check("msb_idle_ready", {31'b0, m_ready_i}, 32'd1);
        @(negedge clk);
        m_valid_i = 1'b0;
        m_data_i  = 16'h0000;
        for (int b = 0; b < 4; b++) begin
            logic [3:0] exp_nib;
            exp_nib = 4'hA + 4'(b);
            if (b != 0) @(negedge clk);
            #1;
            check($sformatf("msb_beat%0d_data", b),  {28'b0, m_data_o},  {28'b0, exp_nib});
            check($sformatf("msb_beat%0d_valid", b), {31'b0, m_valid_o}, 32'd1);
            check($sformatf("msb_beat%0d_last", b),  {31'b0, m_last_o},  (b == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        check("msb_done_valid", {31'b0, m_valid_o}, 32'd0);

        // ---------------- reset mid-word ----------------
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 32'h12345678;
        ready_o = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 32'h00000000;
        #1;
        check("mid_beat0", {24'b0, data_o}, 32'h78);
        @(negedge clk);
        #1;
        check("mid_beat1", {24'b0, data_o}, 32'h56);
        @(negedge clk);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        check("mid_rst_data",  {24'b0, data_o},  32'd0);
        check("mid_rst_last",  {31'b0, last_o},  32'd0);
        check("mid_rst_ready", {31'b0, ready_i}, 32'd1);
        @(negedge clk);
        rstn_i  = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'h9ABCDEF0;
        #1;
        check("post_rst_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 32'h00000000;
        #1;
        check("post_rst_b0", {24'b0, data_o}, 32'hF0);
        @(negedge clk);
        #1;
        check("post_rst_b1", {24'b0, data_o}, 32'hDE);
        @(negedge clk);
        #1;
        check("post_rst_b2", {24'b0, data_o}, 32'hBC);
        @(negedge clk);
        #1;
        check("post_rst_b3", {24'b0, data_o}, 32'h9A);
        check("post_rst_last", {31'b0, last_o}, 32'd1);

        // ---------------- FIFO-fed, random back-pressure ----------------
        fifo_q.push_back(32'h13121110);
        fifo_q.push_back(32'h17161514);
        fifo_q.push_back(32'h1B1A1918);
        got = 0;
        for (int cyc = 0; cyc < 400 && got < 12; cyc++) begin
            @(negedge clk);
            valid_i = (fifo_q.size() > 0);
            data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h00000000;
            ready_o = 1'($urandom_range(0, 1));
            #1;
            if (valid_o && ready_o) begin
                check($sformatf("fifo_beat%0d_data", got), {24'b0, data_o}, 32'h10 + 32'(got));
                check($sformatf("fifo_beat%0d_last", got), {31'b0, last_o},
                      ((got % 4) == 3) ? 32'd1 : 32'd0);
                got++;
            end
            if (valid_i && ready_i) begin
                void'(fifo_q.pop_front());
            end
        end
        check("fifo_beat_count", 32'(got), 32'd12);
        @(negedge clk);
        valid_i = 1'b0;
        ready_o = 1'b1;
        #1;
        check("fifo_drained_valid", {31'b0, valid_o}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
